// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display
//
// Sequential binary-to-BCD converter that feeds a seven_seg display driver.
// An unsigned binary value is captured on an accepted START and converted with
// iterative double-dabble, one bit per CE-qualified clock. When the conversion
// completes, the packed BCD digits and a leading-zero blanking mask are
// registered and DONE pulses for one clock. A value that does not fit in
// DIGIT_COUNT decimal digits shows as all 'E' digits and raises OVERFLOW.
//
// Ports
//   clk      : system clock, rising edge
//   RESET    : synchronous active-high reset; overrides every other input
//   CE       : clock enable; the FSM and datapath advance only when high
//   BIN      : unsigned binary value, sampled when START is accepted
//   START    : conversion request, accepted only in IDLE with CE high
//   NUMBER   : packed BCD result; digit i is NUMBER[4i+3:4i]
//   AN_MASK  : 1 = blank anode i (leading zeros); bit 0 is never blanked
//   BUSY     : high while the FSM is not in IDLE
//   DONE     : one-clock pulse when NUMBER/AN_MASK/OVERFLOW are updated
//   OVERFLOW : registered with the result; BIN exceeded 10^DIGIT_COUNT-1
module bin_to_bcd_display #(
  parameter int BIN_WIDTH   = 27,
  parameter int DIGIT_COUNT = 8,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     CE,
  input  logic [BIN_WIDTH-1:0]     BIN,
  input  logic                     START,
  output logic [DIGIT_COUNT*4-1:0] NUMBER,
  output logic [DIGIT_COUNT-1:0]   AN_MASK,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     OVERFLOW
);

  localparam int NUM_W = DIGIT_COUNT * 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] FINISH  = 2'd2;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Largest value that still fits in the display.
  localparam logic [63:0] MAX_VAL = pow10(DIGIT_COUNT) - 64'd1;

  // Idle display after reset: a single "0" on anode 0.
  localparam logic [DIGIT_COUNT-1:0] MASK_RST =
    BLANK_ZEROS ? {{(DIGIT_COUNT-1){1'b1}}, 1'b0} : '0;

  localparam logic [NUM_W-1:0] ERR_PATTERN = {DIGIT_COUNT{4'hE}};

  logic [1:0]             state_q,    state_d;
  logic [BIN_WIDTH-1:0]   shift_q,    shift_d;
  logic [NUM_W-1:0]       scratch_q,  scratch_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic                   ovf_flag_q, ovf_flag_d;
  logic [NUM_W-1:0]       number_q,   number_d;
  logic [DIGIT_COUNT-1:0] an_mask_q,  an_mask_d;
  logic                   overflow_q, overflow_d;
  logic                   done_q,     done_d;

  logic [NUM_W-1:0]       scratch_adj;
  logic [DIGIT_COUNT-1:0] blank_mask;

  // Double-dabble correction: any digit >= 5 gets +3 so that the following
  // left shift carries correctly into the next decimal digit.
  for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : g_adj
    assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                    ? scratch_q[4*gi +: 4] + 4'd3
                                    : scratch_q[4*gi +: 4];
  end

  // Anode i is blanked when it and every more significant digit are zero.
  // Anode 0 always stays lit so that zero shows as "0".
  for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : g_blank
    if (gi == 0) begin : g_lsd
      assign blank_mask[gi] = 1'b0;
    end else begin : g_upper
      assign blank_mask[gi] = BLANK_ZEROS && (scratch_q[NUM_W-1:4*gi] == '0);
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    number_d   = number_q;
    an_mask_d  = an_mask_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (CE && START) begin
          shift_d    = BIN;
          scratch_d  = '0;
          ovf_flag_d = (64'(BIN) > MAX_VAL);
          cnt_d      = CNT_W'(BIN_WIDTH);
          state_d    = CONVERT;
        end
      end

      CONVERT: begin
        if (CE) begin
          {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        if (CE) begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (ovf_flag_q) begin
            number_d   = ERR_PATTERN;
            an_mask_d  = '0;
            overflow_d = 1'b1;
          end else begin
            number_d   = scratch_q;
            an_mask_d  = blank_mask;
            overflow_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // DONE is not CE-gated: done_d defaults low, so the pulse always lasts one clk.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      number_q   <= '0;
      an_mask_q  <= MASK_RST;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      number_q   <= number_d;
      an_mask_q  <= an_mask_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign NUMBER   = number_q;
  assign AN_MASK  = an_mask_q;
  assign OVERFLOW = overflow_q;
  assign DONE     = done_q;
  assign BUSY     = (state_q != IDLE);

endmodule
